avst_rx_buffer: RTL and testbench
=================================

# avst_rx_buffer

Avalon-ST byte-stream sink that terminates the `data/end/valid/ready` packet interface produced by the stream blocks, such as the adder output. It is the receiving end of that interface and drives `ready` towards the upstream source. Accepted beats are buffered in a show-ahead FIFO that a local consumer drains. Per-packet length and modulo-256 byte sum are reported on end-of-packet, so benches and downstream logic can check streams without reassembling them.

## Interface
- `DEPTH`, default 16: FIFO depth in beats; power of two, at least 2.
- `CNT_W`, default $clog2(DEPTH)+1: occupancy counter width.
- `clk` in 1: single clock; all logic on posedge.
- `reset` in 1: synchronous, active-high.
- `data_in` in 8: upstream beat data.
- `end_in` in 1: upstream end-of-packet marker for this beat.
- `valid_in` in 1: upstream beat valid.
- `ready_in` out 1: sink can accept a beat this cycle; readyLatency 0.
- `rd_data` out 8: head beat data (show-ahead).
- `rd_end` out 1: head beat end-of-packet marker.
- `rd_valid` out 1: FIFO non-empty.
- `rd_ready` in 1: consumer pops the head when `rd_valid && rd_ready`.
- `pkt_avail` out 1: at least one complete packet (stored end beat) is in the FIFO.
- `stat_valid` out 1: one-cycle pulse, packet statistics valid.
- `stat_len` out 8: beats in the last completed packet, saturating at 255.
- `stat_sum` out 8: sum of that packet's data bytes, mod 256.

## Operation
- **Push:** happens when `valid_in && ready_in`; stores {end_in, data_in} at the write pointer.
- **Pop:** happens when `rd_valid && rd_ready`.
- **Ready:** `ready_in = (count != DEPTH)`, decoded from the registered count only. There is no combinational path from `rd_ready` or `valid_in` to `ready_in`.
- **Count:**
  - push only: +1.
  - pop only: −1.
  - push and pop together: unchanged.
  - Pointers wrap modulo DEPTH.
- **Full:** `valid_in` while `ready_in=0` is ignored. The upstream source holds the beat; nothing is dropped.
- **Empty:** `rd_ready` while `rd_valid=0` is ignored.
- **Packet counter `pkts`:**
  - +1 on push of an end beat.
  - −1 on pop of an end beat.
  - both in the same cycle: unchanged.
  - `pkt_avail = (pkts != 0)`.
- **Statistics accumulator:** two states, IDLE and IN_PKT.
  - Push of a non-end beat:
    - From IDLE: `acc_len←1`, `acc_sum←data`, go to IN_PKT.
    - From IN_PKT: `acc_len←min(acc_len+1,255)`, `acc_sum←acc_sum+data` (8-bit wrap).
  - Push of an end beat, from either state:
    - `stat_len←` final length, counting this beat.
    - `stat_sum←` final sum, including this beat.
    - `stat_valid←1` for one cycle; go to IDLE.
  - A single-beat packet (end on the first beat) gives `stat_len=1`.
- `stat_len` and `stat_sum` hold their values until the next end beat.
- **Reset:**
  - Clears pointers, `count`, `pkts`, accumulator and state.
  - A partial packet in progress is discarded; its remaining beats arriving after reset count as a new packet.

## Timing
- **Reset values:** `ready_in=0` during reset and 1 from the first cycle after release. `rd_valid=0`, `rd_data=0`, `rd_end=0`, `pkt_avail=0`, `stat_valid=0`, `stat_len=0`, `stat_sum=0`.
- **Latency:** a beat pushed at edge N appears on `rd_*` after edge N (one cycle) when the FIFO was empty.
- **Stats:** `stat_valid` is high for the cycle after the edge that accepted the end beat.
- **Full boundary:** a pop at edge N on a full FIFO raises `ready_in` after edge N. A push in that same cycle is not possible because `ready_in` was 0.
- **Throughput:** one beat per cycle with `rd_ready` held high.

## Structure
- **Package `avst_pkg`:**
  - `BYTE_W=8`.
  - typedef `avst_beat_t` {logic eop; logic [7:0] data}.
  - typedef `stat_state_t` {IDLE, IN_PKT}.
- **Sub-module `avst_beat_fifo`:**
  - Parameterised show-ahead FIFO of `avst_beat_t` with count output.
  - The top level adds the packet counter and the statistics FSM.

## Test plan
- **Basic packet** (DEPTH=16, `rd_ready=1`): push 3, 5, 7(end) → `stat_valid` pulse with `stat_len=3`, `stat_sum=15`. `rd_*` shows 3, 5, 7 with `rd_end` set only on 7.
- **Sum wrap:** push 200, 100(end) → `stat_len=2`, `stat_sum=44`. A following single beat 9(end) → `stat_len=1`, `stat_sum=9`.
- **Backpressure** (DEPTH=4, `rd_ready=0`, `valid_in` held): 4 beats accepted, then `ready_in=0` with `count=4`. Raise `rd_ready` for one cycle → `ready_in=1` the next cycle and the 5th beat is accepted. Beat order is preserved.
- **Simultaneous push/pop** at `count=2` for 10 cycles → count stays 2 and the data stream is unchanged.
- **Packet counter:** push 1(end), 2(end) with `rd_ready=0` → `pkt_avail=1`, `pkts=2`. Pop 2 beats → `pkt_avail=0`.
- **Reset mid-packet:** push 4, 6 (no end), assert reset for 1 cycle → all outputs at reset values. Then push 9(end) → `stat_len=1`, `stat_sum=9`.
- **Length saturation:** 300 beats of value 1, the last with end, `rd_ready=1` → `stat_len=255`, `stat_sum=44`.

Source files
------------

// File: rtl/avst_pkg.sv
// Shared types for the Avalon-ST receive buffer: beat payload and statistics FSM states.
package avst_pkg;

  localparam int unsigned BYTE_W = 8;

  typedef struct packed {
    logic              eop;
    logic [BYTE_W-1:0] data;
  } avst_beat_t;

  typedef enum logic {
    IDLE,
    IN_PKT
  } stat_state_t;

endpackage

// File: rtl/avst_beat_fifo.sv
// Show-ahead FIFO of stream beats; the head entry is always visible on rd_beat.
module avst_beat_fifo
  import avst_pkg::*;
#(
  parameter int unsigned DEPTH = 16,
  parameter int unsigned CNT_W = $clog2(DEPTH) + 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  avst_beat_t       wr_beat,
  input  logic             pop,
  output avst_beat_t       rd_beat,
  output logic [CNT_W-1:0] count,
  output logic             not_full
);

  localparam int unsigned PTR_W = $clog2(DEPTH);

  avst_beat_t       mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [CNT_W-1:0] count_d;

  always_comb begin
    count_d = count;
    if (push && !pop) begin
      count_d = count + CNT_W'(1);
    end else if (pop && !push) begin
      count_d = count - CNT_W'(1);
    end
  end

  // Storage is cleared on reset so the head reads as zero while empty.
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      not_full <= 1'b0;
      for (int i = 0; i < int'(DEPTH); i++) begin
        mem[i] <= '0;
      end
    end else begin
      if (push) begin
        mem[wr_ptr] <= wr_beat;
        wr_ptr      <= wr_ptr + PTR_W'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + PTR_W'(1);
      end
      count    <= count_d;
      not_full <= (count_d != CNT_W'(DEPTH));
    end
  end

  assign rd_beat = mem[rd_ptr];

endmodule

// File: rtl/avst_rx_buffer.sv
// Avalon-ST byte-stream sink: buffers beats for a local consumer and reports
// per-packet length and modulo-256 byte sum on end-of-packet.
module avst_rx_buffer
  import avst_pkg::*;
#(
  parameter int unsigned DEPTH = 16,
  parameter int unsigned CNT_W = $clog2(DEPTH) + 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [BYTE_W-1:0] data_in,
  input  logic              end_in,
  input  logic              valid_in,
  output logic              ready_in,
  output logic [BYTE_W-1:0] rd_data,
  output logic              rd_end,
  output logic              rd_valid,
  input  logic              rd_ready,
  output logic              pkt_avail,
  output logic              stat_valid,
  output logic [BYTE_W-1:0] stat_len,
  output logic [BYTE_W-1:0] stat_sum
);

  localparam logic [BYTE_W-1:0] LEN_MAX = '1;

  logic             push;
  logic             pop;
  avst_beat_t       wr_beat;
  avst_beat_t       rd_beat;
  logic [CNT_W-1:0] count;
  logic [CNT_W-1:0] pkts;
  logic [CNT_W-1:0] pkts_d;

  stat_state_t       state;
  stat_state_t       state_d;
  logic [BYTE_W-1:0] acc_len;
  logic [BYTE_W-1:0] acc_len_d;
  logic [BYTE_W-1:0] acc_sum;
  logic [BYTE_W-1:0] acc_sum_d;
  logic [BYTE_W-1:0] base_len;
  logic [BYTE_W-1:0] base_sum;
  logic [BYTE_W-1:0] next_len;
  logic [BYTE_W-1:0] next_sum;
  logic              stat_valid_d;
  logic [BYTE_W-1:0] stat_len_d;
  logic [BYTE_W-1:0] stat_sum_d;

  assign push     = valid_in && ready_in;
  assign pop      = rd_valid && rd_ready;
  assign wr_beat  = '{eop: end_in, data: data_in};
  assign rd_valid = (count != '0);
  assign rd_data  = rd_beat.data;
  assign rd_end   = rd_beat.eop;

  avst_beat_fifo #(
    .DEPTH (DEPTH),
    .CNT_W (CNT_W)
  ) u_fifo (
    .clk      (clk),
    .reset    (reset),
    .push     (push),
    .wr_beat  (wr_beat),
    .pop      (pop),
    .rd_beat  (rd_beat),
    .count    (count),
    .not_full (ready_in)
  );

  // Stored complete packets: end beats pushed minus end beats popped.
  always_comb begin
    pkts_d = pkts;
    if ((push && end_in) && !(pop && rd_end)) begin
      pkts_d = pkts + CNT_W'(1);
    end else if ((pop && rd_end) && !(push && end_in)) begin
      pkts_d = pkts - CNT_W'(1);
    end
  end

  // Statistics FSM next-state and accumulator update.
  always_comb begin
    state_d      = state;
    acc_len_d    = acc_len;
    acc_sum_d    = acc_sum;
    stat_valid_d = 1'b0;
    stat_len_d   = stat_len;
    stat_sum_d   = stat_sum;
    base_len     = '0;
    base_sum     = '0;
    case (state)
      IN_PKT: begin
        base_len = acc_len;
        base_sum = acc_sum;
      end
      default: begin
        base_len = '0;
        base_sum = '0;
      end
    endcase
    next_len = (base_len == LEN_MAX) ? LEN_MAX : base_len + BYTE_W'(1);
    next_sum = base_sum + data_in;
    if (push) begin
      if (end_in) begin
        stat_len_d   = next_len;
        stat_sum_d   = next_sum;
        stat_valid_d = 1'b1;
        state_d      = IDLE;
      end else begin
        acc_len_d = next_len;
        acc_sum_d = next_sum;
        state_d   = IN_PKT;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      acc_len    <= '0;
      acc_sum    <= '0;
      stat_valid <= 1'b0;
      stat_len   <= '0;
      stat_sum   <= '0;
      pkts       <= '0;
      pkt_avail  <= 1'b0;
    end else begin
      state      <= state_d;
      acc_len    <= acc_len_d;
      acc_sum    <= acc_sum_d;
      stat_valid <= stat_valid_d;
      stat_len   <= stat_len_d;
      stat_sum   <= stat_sum_d;
      pkts       <= pkts_d;
      pkt_avail  <= (pkts_d != '0);
    end
  end

endmodule

// File: tb/tb_avst_rx_buffer.sv
// Directed bench for avst_rx_buffer with a 4-deep FIFO so backpressure is reachable.
module tb_avst_rx_buffer;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [7:0] data_in = '0;
  logic       end_in = 1'b0;
  logic       valid_in = 1'b0;
  logic       ready_in;
  logic [7:0] rd_data;
  logic       rd_end;
  logic       rd_valid;
  logic       rd_ready = 1'b0;
  logic       pkt_avail;
  logic       stat_valid;
  logic [7:0] stat_len;
  logic [7:0] stat_sum;

  int vectors = 0;
  int miscompares = 0;

  avst_rx_buffer #(.DEPTH(4)) dut (
    .clk        (clk),
    .reset      (reset),
    .data_in    (data_in),
    .end_in     (end_in),
    .valid_in   (valid_in),
    .ready_in   (ready_in),
    .rd_data    (rd_data),
    .rd_end     (rd_end),
    .rd_valid   (rd_valid),
    .rd_ready   (rd_ready),
    .pkt_avail  (pkt_avail),
    .stat_valid (stat_valid),
    .stat_len   (stat_len),
    .stat_sum   (stat_sum)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Offers one beat until accepted; returns just after the accepting edge.
  task automatic send(input logic [7:0] d, input logic e);
    int   n;
    logic acc;
    n = 0;
    data_in  = d;
    end_in   = e;
    valid_in = 1'b1;
    do begin
      acc = ready_in;
      tick();
      n++;
    end while (!acc && n < 50);
    valid_in = 1'b0;
    end_in   = 1'b0;
    vectors++;
    if (acc !== 1'b1) begin
      miscompares++;
      $display("FAIL send_timeout: beat %0d not accepted, ready_in=%b expected 1", d, acc);
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    tick();
    tick();
    vectors++;
    if ({ready_in, rd_valid, rd_data, rd_end, pkt_avail, stat_valid, stat_len, stat_sum} !== 29'd0) begin
      miscompares++;
      $display("FAIL reset_values: got rdy=%b rv=%b rd=%0d re=%b pa=%b sv=%b sl=%0d ss=%0d expected all 0",
               ready_in, rd_valid, rd_data, rd_end, pkt_avail, stat_valid, stat_len, stat_sum);
    end
    reset = 1'b0;
    tick();
    vectors++;
    if (ready_in !== 1'b1) begin
      miscompares++;
      $display("FAIL ready_after_reset: got %b expected 1", ready_in);
    end
  endtask

  task automatic test_basic();
    logic [7:0] d [3] = '{8'd3, 8'd5, 8'd7};
    rd_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      send(d[i], i == 2);
      vectors++;
      if ({rd_valid, rd_end, rd_data, stat_valid} !== {1'b1, i == 2, d[i], i == 2}) begin
        miscompares++;
        $display("FAIL basic_head[%0d]: got v=%b e=%b d=%0d sv=%b expected v=1 e=%b d=%0d sv=%b",
                 i, rd_valid, rd_end, rd_data, stat_valid, i == 2, d[i], i == 2);
      end
    end
    vectors++;
    if ({stat_len, stat_sum, pkt_avail} !== {8'd3, 8'd15, 1'b1}) begin
      miscompares++;
      $display("FAIL basic_stats: got len=%0d sum=%0d pa=%b expected len=3 sum=15 pa=1",
               stat_len, stat_sum, pkt_avail);
    end
    tick();
    vectors++;
    if ({stat_valid, rd_valid, pkt_avail, stat_len} !== {1'b0, 1'b0, 1'b0, 8'd3}) begin
      miscompares++;
      $display("FAIL basic_after: got sv=%b rv=%b pa=%b len=%0d expected sv=0 rv=0 pa=0 len=3",
               stat_valid, rd_valid, pkt_avail, stat_len);
    end
  endtask

  task automatic test_sum_wrap();
    rd_ready = 1'b1;
    send(8'd200, 1'b0);
    send(8'd100, 1'b1);
    vectors++;
    if ({stat_valid, stat_len, stat_sum} !== {1'b1, 8'd2, 8'd44}) begin
      miscompares++;
      $display("FAIL sum_wrap: got sv=%b len=%0d sum=%0d expected sv=1 len=2 sum=44",
               stat_valid, stat_len, stat_sum);
    end
    send(8'd9, 1'b1);
    vectors++;
    if ({stat_valid, stat_len, stat_sum} !== {1'b1, 8'd1, 8'd9}) begin
      miscompares++;
      $display("FAIL single_beat: got sv=%b len=%0d sum=%0d expected sv=1 len=1 sum=9",
               stat_valid, stat_len, stat_sum);
    end
    tick();
  endtask

  task automatic test_backpressure();
    rd_ready = 1'b0;
    for (int i = 0; i < 4; i++) send(8'(10 + i), 1'b0);
    vectors++;
    if (ready_in !== 1'b0) begin
      miscompares++;
      $display("FAIL full_ready: got %b expected 0", ready_in);
    end
    data_in  = 8'd14;
    end_in   = 1'b1;
    valid_in = 1'b1;
    tick();
    tick();
    vectors++;
    if ({ready_in, rd_data} !== {1'b0, 8'd10}) begin
      miscompares++;
      $display("FAIL full_hold: got rdy=%b head=%0d expected rdy=0 head=10", ready_in, rd_data);
    end
    rd_ready = 1'b1;
    tick();
    rd_ready = 1'b0;
    vectors++;
    if ({ready_in, rd_data} !== {1'b1, 8'd11}) begin
      miscompares++;
      $display("FAIL pop_frees: got rdy=%b head=%0d expected rdy=1 head=11", ready_in, rd_data);
    end
    tick();
    valid_in = 1'b0;
    end_in   = 1'b0;
    vectors++;
    if ({ready_in, stat_valid, stat_len, stat_sum} !== {1'b0, 1'b1, 8'd5, 8'd60}) begin
      miscompares++;
      $display("FAIL fifth_beat: got rdy=%b sv=%b len=%0d sum=%0d expected rdy=0 sv=1 len=5 sum=60",
               ready_in, stat_valid, stat_len, stat_sum);
    end
    rd_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      vectors++;
      if ({rd_valid, rd_data, rd_end} !== {1'b1, 8'(11 + i), i == 3}) begin
        miscompares++;
        $display("FAIL bp_order[%0d]: got v=%b d=%0d e=%b expected v=1 d=%0d e=%b",
                 i, rd_valid, rd_data, rd_end, 11 + i, i == 3);
      end
      tick();
    end
    rd_ready = 1'b0;
    vectors++;
    if (rd_valid !== 1'b0) begin
      miscompares++;
      $display("FAIL bp_drained: got rd_valid=%b expected 0", rd_valid);
    end
  endtask

  task automatic test_simultaneous();
    rd_ready = 1'b0;
    send(8'd20, 1'b0);
    send(8'd21, 1'b0);
    valid_in = 1'b1;
    end_in   = 1'b0;
    rd_ready = 1'b1;
    for (int i = 0; i < 10; i++) begin
      data_in = 8'(22 + i);
      vectors++;
      if ({ready_in, rd_valid, rd_data} !== {1'b1, 1'b1, 8'(20 + i)}) begin
        miscompares++;
        $display("FAIL simul[%0d]: got rdy=%b v=%b d=%0d expected rdy=1 v=1 d=%0d",
                 i, ready_in, rd_valid, rd_data, 20 + i);
      end
      tick();
    end
    valid_in = 1'b0;
    rd_ready = 1'b0;
    send(8'd32, 1'b0);
    send(8'd33, 1'b1);
    vectors++;
    if ({ready_in, stat_valid, stat_len, stat_sum} !== {1'b0, 1'b1, 8'd14, 8'd115}) begin
      miscompares++;
      $display("FAIL simul_count: got rdy=%b sv=%b len=%0d sum=%0d expected rdy=0 sv=1 len=14 sum=115",
               ready_in, stat_valid, stat_len, stat_sum);
    end
    rd_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      vectors++;
      if ({rd_valid, rd_data, rd_end} !== {1'b1, 8'(30 + i), i == 3}) begin
        miscompares++;
        $display("FAIL simul_drain[%0d]: got v=%b d=%0d e=%b expected v=1 d=%0d e=%b",
                 i, rd_valid, rd_data, rd_end, 30 + i, i == 3);
      end
      tick();
    end
    rd_ready = 1'b0;
  endtask

  task automatic test_pkt_counter();
    rd_ready = 1'b0;
    send(8'd1, 1'b1);
    vectors++;
    if (pkt_avail !== 1'b1) begin
      miscompares++;
      $display("FAIL pkt_one: got pkt_avail=%b expected 1", pkt_avail);
    end
    send(8'd2, 1'b1);
    vectors++;
    if ({pkt_avail, rd_data, rd_end} !== {1'b1, 8'd1, 1'b1}) begin
      miscompares++;
      $display("FAIL pkt_two: got pa=%b d=%0d e=%b expected pa=1 d=1 e=1", pkt_avail, rd_data, rd_end);
    end
    rd_ready = 1'b1;
    tick();
    vectors++;
    if ({pkt_avail, rd_data} !== {1'b1, 8'd2}) begin
      miscompares++;
      $display("FAIL pkt_pop1: got pa=%b d=%0d expected pa=1 d=2", pkt_avail, rd_data);
    end
    tick();
    rd_ready = 1'b0;
    vectors++;
    if ({pkt_avail, rd_valid} !== 2'b00) begin
      miscompares++;
      $display("FAIL pkt_pop2: got pa=%b v=%b expected pa=0 v=0", pkt_avail, rd_valid);
    end
  endtask

  task automatic test_reset_mid();
    rd_ready = 1'b0;
    send(8'd4, 1'b0);
    send(8'd6, 1'b0);
    reset = 1'b1;
    tick();
    vectors++;
    if ({ready_in, rd_valid, rd_data, rd_end, pkt_avail, stat_valid, stat_len, stat_sum} !== 29'd0) begin
      miscompares++;
      $display("FAIL mid_reset: got rdy=%b rv=%b rd=%0d re=%b pa=%b sv=%b sl=%0d ss=%0d expected all 0",
               ready_in, rd_valid, rd_data, rd_end, pkt_avail, stat_valid, stat_len, stat_sum);
    end
    reset = 1'b0;
    send(8'd9, 1'b1);
    vectors++;
    if ({stat_valid, stat_len, stat_sum, rd_data} !== {1'b1, 8'd1, 8'd9, 8'd9}) begin
      miscompares++;
      $display("FAIL after_reset_pkt: got sv=%b len=%0d sum=%0d head=%0d expected sv=1 len=1 sum=9 head=9",
               stat_valid, stat_len, stat_sum, rd_data);
    end
    rd_ready = 1'b1;
    tick();
    rd_ready = 1'b0;
  endtask

  task automatic test_saturation();
    rd_ready = 1'b1;
    for (int i = 0; i < 300; i++) begin
      send(8'd1, i == 299);
      if (i == 150) begin
        vectors++;
        if ({stat_valid, stat_len} !== {1'b0, 8'd1}) begin
          miscompares++;
          $display("FAIL sat_mid: got sv=%b len=%0d expected sv=0 len=1", stat_valid, stat_len);
        end
      end
    end
    vectors++;
    if ({stat_valid, stat_len, stat_sum} !== {1'b1, 8'd255, 8'd44}) begin
      miscompares++;
      $display("FAIL saturation: got sv=%b len=%0d sum=%0d expected sv=1 len=255 sum=44",
               stat_valid, stat_len, stat_sum);
    end
    tick();
    vectors++;
    if ({stat_valid, stat_len, stat_sum} !== {1'b0, 8'd255, 8'd44}) begin
      miscompares++;
      $display("FAIL stat_hold: got sv=%b len=%0d sum=%0d expected sv=0 len=255 sum=44",
               stat_valid, stat_len, stat_sum);
    end
    rd_ready = 1'b0;
  endtask

  initial begin
    test_reset();
    test_basic();
    test_sum_wrap();
    test_backpressure();
    test_simultaneous();
    test_pkt_counter();
    test_reset_mid();
    test_saturation();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
